// File: rtl/serial_add_ctrl_if.sv
// Request/result and full-adder-cell signals of serial_add_ctrl.
// The sub port exists only when SERIAL_ADD_CTRL_SUB_EN is defined.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADD_CTRL_SUB_EN
    logic             sub;
`endif
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_s;
    logic             fa_cout;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADD_CTRL_SUB_EN
    modport slave (
        input  start, a, b, cin, sub, fa_s, fa_cout,
        output fa_a, fa_b, fa_cin, busy, done, sum, cout
    );
    modport master (
        output start, a, b, cin, sub, fa_s, fa_cout,
        input  fa_a, fa_b, fa_cin, busy, done, sum, cout
    );
`else
    modport slave (
        input  start, a, b, cin, fa_s, fa_cout,
        output fa_a, fa_b, fa_cin, busy, done, sum, cout
    );
    modport master (
        output start, a, b, cin, fa_s, fa_cout,
        input  fa_a, fa_b, fa_cin, busy, done, sum, cout
    );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller driving one external full-adder cell, LSB first.
// Define SERIAL_ADD_CTRL_SUB_EN to add the sub input (a - b via ~b + 1).
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    serial_add_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef SERIAL_ADD_CTRL_SUB_EN
    // Two's-complement subtract: invert b and force the carry-in to one.
    assign b_load = bus.sub ? ~bus.b : bus.b;
    assign c_load = bus.sub ? 1'b1   : bus.cin;
`else
    assign b_load = bus.b;
    assign c_load = bus.cin;
`endif

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        c_d     = c_q;
        s_sh_d  = s_sh_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = b_load;
                    c_d     = c_load;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_sh_d = {bus.fa_s, s_sh_q[WIDTH-1:1]};
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                c_d    = bus.fa_cout;
                // Hold the counter on the last bit so it never wraps.
                if (cnt_q == LAST) begin
                    sum_d   = {bus.fa_s, s_sh_q[WIDTH-1:1]};
                    cout_d  = bus.fa_cout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            c_q     <= 1'b0;
            s_sh_q  <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            c_q     <= c_d;
            s_sh_q  <= s_sh_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    logic run;
    assign run = (state_q == RUN);

    assign bus.fa_a   = run & a_sh_q[0];
    assign bus.fa_b   = run & b_sh_q[0];
    assign bus.fa_cin = run & c_q;
    assign bus.busy   = run;
    assign bus.done   = (state_q == DONE);
    assign bus.sum    = sum_q;
    assign bus.cout   = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with an ideal full-adder model, WIDTH = 4.
module tb_serial_add_ctrl;
    localparam int W = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign bus.fa_s    = bus.fa_a ^ bus.fa_b ^ bus.fa_cin;
    assign bus.fa_cout = (bus.fa_a & bus.fa_b) | (bus.fa_a & bus.fa_cin) | (bus.fa_b & bus.fa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with a one-cycle start pulse; returns in RUN cycle 1.
    task automatic apply_start(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic cv, input logic sv);
        bus.a   = av;
        bus.b   = bv;
        bus.cin = cv;
`ifdef SERIAL_ADD_CTRL_SUB_EN
        bus.sub = sv;
`endif
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Bounded wait for done; reports cycles waited, busy cycles seen, result change before done.
    task automatic wait_done(output int cycles, output int busy_cycles, output bit changed);
        logic [W-1:0] s0;
        logic         c0;
        s0 = bus.sum;
        c0 = bus.cout;
        cycles = 0;
        busy_cycles = 0;
        changed = 1'b0;
        while (bus.done !== 1'b1 && cycles < 20) begin
            if (bus.busy === 1'b1) busy_cycles++;
            if (bus.sum !== s0 || bus.cout !== c0) changed = 1'b1;
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.busy, bus.done, bus.sum, bus.cout} !== {1'b0, 1'b0, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b sum=%b cout=%b, required all 0",
                     bus.busy, bus.done, bus.sum, bus.cout);
        end
        checks++;
        if ({bus.fa_a, bus.fa_b, bus.fa_cin} !== 3'b000) begin
            errors++;
            $display("FAIL reset_fa: fa=%b%b%b, required 000", bus.fa_a, bus.fa_b, bus.fa_cin);
        end
        rst = 1'b0;
        tick();
        $display("test_reset: busy=%b done=%b sum=%b cout=%b", bus.busy, bus.done, bus.sum, bus.cout);
    endtask

    task automatic test_basic();
        int cyc, bcyc;
        bit chg;
        apply_start(4'b1010, 4'b1011, 1'b0, 1'b0);
        checks++;
        if ({bus.fa_a, bus.fa_b, bus.fa_cin} !== 3'b010) begin
            errors++;
            $display("FAIL basic_fa_bit0: fa=%b%b%b, required 010", bus.fa_a, bus.fa_b, bus.fa_cin);
        end
        wait_done(cyc, bcyc, chg);
        checks++;
        if (cyc !== W || bcyc !== W) begin
            errors++;
            $display("FAIL basic_latency: done after %0d cycles busy %0d, required %0d/%0d", cyc, bcyc, W, W);
        end
        checks++;
        if ({bus.cout, bus.sum} !== 5'b1_0101 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: cout=%b sum=%b busy=%b, required 1 0101 0", bus.cout, bus.sum, bus.busy);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || {bus.cout, bus.sum} !== 5'b1_0101) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b cout=%b sum=%b, required 0 1 0101", bus.done, bus.cout, bus.sum);
        end
        $display("test_basic: 1010+1011+0 -> cout=%b sum=%b cycles=%0d", bus.cout, bus.sum, cyc);
    endtask

    task automatic test_cin();
        int cyc, bcyc;
        bit chg;
        apply_start(4'b1010, 4'b1011, 1'b1, 1'b0);
        wait_done(cyc, bcyc, chg);
        checks++;
        if ({bus.cout, bus.sum} !== 5'b1_0110 || cyc !== W) begin
            errors++;
            $display("FAIL cin_result: cout=%b sum=%b cycles=%0d, required 1 0110 %0d", bus.cout, bus.sum, cyc, W);
        end
        tick();
        $display("test_cin: 1010+1011+1 -> cout=%b sum=%b", bus.cout, bus.sum);
    endtask

    task automatic test_hold();
        int cyc, bcyc;
        bit chg;
        apply_start(4'b1010, 4'b0011, 1'b1, 1'b0);
        wait_done(cyc, bcyc, chg);
        checks++;
        if ({bus.cout, bus.sum} !== 5'b0_1110) begin
            errors++;
            $display("FAIL hold_first: cout=%b sum=%b, required 0 1110", bus.cout, bus.sum);
        end
        tick();
        apply_start(4'b1000, 4'b0011, 1'b1, 1'b0);
        checks++;
        if (bus.sum !== 4'b1110 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_mid_run: sum=%b busy=%b, required 1110 1", bus.sum, bus.busy);
        end
        wait_done(cyc, bcyc, chg);
        checks++;
        if (chg !== 1'b0) begin
            errors++;
            $display("FAIL hold_unchanged: result changed before done, required held");
        end
        checks++;
        if ({bus.cout, bus.sum} !== 5'b0_1100) begin
            errors++;
            $display("FAIL hold_second: cout=%b sum=%b, required 0 1100", bus.cout, bus.sum);
        end
        tick();
        $display("test_hold: 1000+0011+1 -> cout=%b sum=%b", bus.cout, bus.sum);
    endtask

    task automatic test_back_to_back();
        int cyc, bcyc;
        bit chg;
        bus.a = 4'b0101;
        bus.b = 4'b0110;
        bus.cin = 1'b0;
`ifdef SERIAL_ADD_CTRL_SUB_EN
        bus.sub = 1'b0;
`endif
        bus.start = 1'b1;
        tick();
        bus.a = 4'b1111;
        bus.b = 4'b1111;
        bus.cin = 1'b1;
        wait_done(cyc, bcyc, chg);
        checks++;
        if ({bus.cout, bus.sum} !== 5'b0_1011 || cyc !== W) begin
            errors++;
            $display("FAIL b2b_first: cout=%b sum=%b cycles=%0d, required 0 1011 %0d", bus.cout, bus.sum, cyc, W);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap: busy=%b done=%b, required 0 0", bus.busy, bus.done);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: busy=%b, required 1", bus.busy);
        end
        bus.start = 1'b0;
        wait_done(cyc, bcyc, chg);
        checks++;
        if ({bus.cout, bus.sum} !== 5'b1_1111 || cyc !== W) begin
            errors++;
            $display("FAIL b2b_second: cout=%b sum=%b cycles=%0d, required 1 1111 %0d", bus.cout, bus.sum, cyc, W);
        end
        tick();
        $display("test_back_to_back: second 1111+1111+1 -> cout=%b sum=%b", bus.cout, bus.sum);
    endtask

    task automatic test_reset_mid_run();
        int cyc, bcyc;
        bit chg;
        apply_start(4'b0110, 4'b0111, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({bus.busy, bus.done, bus.sum, bus.cout} !== {1'b0, 1'b0, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL midrst_clear: busy=%b done=%b sum=%b cout=%b, required all 0",
                     bus.busy, bus.done, bus.sum, bus.cout);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_done: done=%b busy=%b, required 0 0", bus.done, bus.busy);
        end
        apply_start(4'b1111, 4'b0001, 1'b0, 1'b0);
        wait_done(cyc, bcyc, chg);
        checks++;
        if ({bus.cout, bus.sum} !== 5'b1_0000 || cyc !== W) begin
            errors++;
            $display("FAIL midrst_after: cout=%b sum=%b cycles=%0d, required 1 0000 %0d", bus.cout, bus.sum, cyc, W);
        end
        tick();
        $display("test_reset_mid_run: 1111+0001+0 -> cout=%b sum=%b", bus.cout, bus.sum);
    endtask

`ifdef SERIAL_ADD_CTRL_SUB_EN
    task automatic test_sub();
        int cyc, bcyc;
        bit chg;
        apply_start(4'd10, 4'd3, 1'b0, 1'b1);
        wait_done(cyc, bcyc, chg);
        checks++;
        if ({bus.cout, bus.sum} !== 5'b1_0111) begin
            errors++;
            $display("FAIL sub_no_borrow: cout=%b sum=%b, required 1 0111", bus.cout, bus.sum);
        end
        tick();
        apply_start(4'd3, 4'd10, 1'b0, 1'b1);
        wait_done(cyc, bcyc, chg);
        checks++;
        if ({bus.cout, bus.sum} !== 5'b0_1001) begin
            errors++;
            $display("FAIL sub_borrow: cout=%b sum=%b, required 0 1001", bus.cout, bus.sum);
        end
        tick();
        $display("test_sub: 3-10 -> cout=%b sum=%b", bus.cout, bus.sum);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
`ifdef SERIAL_ADD_CTRL_SUB_EN
        bus.sub = 1'b0;
`endif
        test_reset();
        test_basic();
        test_cin();
        test_hold();
        test_back_to_back();
        test_reset_mid_run();
`ifdef SERIAL_ADD_CTRL_SUB_EN
        test_sub();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
